// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 peripheral I/O arbiter: FSM state encoding,
// peripheral base-address decode constants and the default read value.
package j1_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } arb_state_e;

    // addr[15:8] values decoded by the chip-select logic
    localparam logic [7:0] IO_BASE_MULT  = 8'h67;
    localparam logic [7:0] IO_BASE_DIV   = 8'h68;
    localparam logic [7:0] IO_BASE_UART  = 8'h69;
    localparam logic [7:0] IO_BASE_DPRAM = 8'h70;

    // Value the read mux returns for an unmapped address
    localparam logic [15:0] IO_DEFAULT_RDATA = 16'h0666;

    // True when the upper address byte selects one of the known peripherals
    function automatic logic io_is_mapped(input logic [7:0] page);
        return (page == IO_BASE_MULT) || (page == IO_BASE_DIV) ||
               (page == IO_BASE_UART) || (page == IO_BASE_DPRAM);
    endfunction

endpackage

// File: rtl/j1_rr_arb2.sv
// Two-way combinational winner select. Round-robin by default: on a tie the
// master that did not own the previous grant wins.
// Build option: J1_IO_ARB_FIXED_PRIO_EN makes master 0 win every tie.
module j1_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

`ifdef J1_IO_ARB_FIXED_PRIO_EN
    // Last owner has no influence under fixed priority
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;
`endif

    // Pick the winner from the current requests
    always_comb begin
        gnt_vld_o = |req_i;
        gnt_idx_o = 1'b0;
        case (req_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
`ifdef J1_IO_ARB_FIXED_PRIO_EN
            2'b11:   gnt_idx_o = 1'b0;
`else
            2'b11:   gnt_idx_o = ~last_owner_i;
`endif
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/j1_io_arbiter.sv
// Two-master arbiter in front of the J1 peripheral I/O bus. Each grant issues
// one rd or wr strobe, waits RD_LAT cycles for read data, then pulses ack.
// Build option: J1_IO_ARB_FIXED_PRIO_EN (handled in j1_rr_arb2) selects fixed
// priority for master 0 instead of round-robin.
module j1_io_arbiter
    import j1_io_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          m0_req_i,
    input  logic          m0_wr_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_wr_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          io_rd_o,
    output logic          io_wr_o,
    output logic [AW-1:0] io_addr_o,
    output logic [DW-1:0] io_dout_o,
    input  logic [DW-1:0] io_din_i,
    output logic          busy_o,
    output logic          owner_o
);

    localparam int         LAT_M1_I = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [2:0] LAT_M1   = LAT_M1_I[2:0];

    arb_state_e    state_q;
    logic          owner_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [2:0]    cnt_q;
    logic          io_rd_q;
    logic          io_wr_q;
    logic          m0_ack_q;
    logic          m1_ack_q;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;

    logic          gnt_vld_d;
    logic          gnt_idx_d;
    logic          sel_wr_d;
    logic [AW-1:0] sel_addr_d;
    logic [DW-1:0] sel_wdata_d;
    logic          cap_d;
    logic          fin_d;

    j1_rr_arb2 u_arb (
        .req_i        ({m1_req_i, m0_req_i}),
        .last_owner_i (owner_q),
        .gnt_vld_o    (gnt_vld_d),
        .gnt_idx_o    (gnt_idx_d)
    );

    // Route the winning master's command towards the latch registers
    assign sel_wr_d    = gnt_idx_d ? m1_wr_i    : m0_wr_i;
    assign sel_addr_d  = gnt_idx_d ? m1_addr_i  : m0_addr_i;
    assign sel_wdata_d = gnt_idx_d ? m1_wdata_i : m0_wdata_i;

    // Read data is sampled either in the strobe cycle (zero latency) or when
    // the wait counter expires; any transfer finishes on the same condition.
    assign cap_d = ((state_q == ST_XFER) && !wr_q && (RD_LAT == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == 3'd0));
    assign fin_d = ((state_q == ST_XFER) && (wr_q || (RD_LAT == 0))) ||
                   ((state_q == ST_WAIT) && (cnt_q == 3'd0));

    // Transfer sequencer with registered strobes, acks and read data
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b1;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= 3'd0;
            io_rd_q    <= 1'b0;
            io_wr_q    <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld_d) begin
                        owner_q <= gnt_idx_d;
                        wr_q    <= sel_wr_d;
                        addr_q  <= sel_addr_d;
                        wdata_q <= sel_wdata_d;
                        io_wr_q <= sel_wr_d;
                        io_rd_q <= ~sel_wr_d;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    io_wr_q <= 1'b0;
                    io_rd_q <= 1'b0;
                    if (fin_d) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q   <= LAT_M1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fin_d) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_ACK: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (cap_d) begin
                if (owner_q) m1_rdata_q <= io_din_i;
                else         m0_rdata_q <= io_din_i;
            end
            if (fin_d) begin
                m0_ack_q <= ~owner_q;
                m1_ack_q <= owner_q;
            end
        end
    end

    assign m0_ack_o   = m0_ack_q;
    assign m1_ack_o   = m1_ack_q;
    assign m0_rdata_o = m0_rdata_q;
    assign m1_rdata_o = m1_rdata_q;
    assign io_rd_o    = io_rd_q;
    assign io_wr_o    = io_wr_q;
    assign io_addr_o  = addr_q;
    assign io_dout_o  = wdata_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign owner_o    = owner_q;

endmodule

// File: doc/j1_io_arbiter.md
Name: j1_io_arbiter

Overview:
- Shares the J1 peripheral I/O bus (mult, div, uart and dp_ram decode at addr[15:8] = 8'h67/68/69/70) between two masters.
- Master 0 is the J1 CPU port; master 1 is a secondary requester (DMA or test engine).
- Each master uses a req/ack handshake. The arbiter sequences exactly one single-beat rd or wr strobe per grant, waits the read latency, and returns the data with ack.
- Sits between the masters and the existing chip-select decoder / read mux.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, cycles from the io_rd_o strobe to sampling io_din_i (0..7; 0 = sample in the strobe cycle).

Ports:
- sys_clk_i  in  1  system clock; all logic on the rising edge.
- sys_rst_i  in  1  reset, asynchronous, active-low.
- m0_req_i  in  1  master 0 request; held until m0_ack_o.
- m0_wr_i  in  1  master 0 direction (1 = write, 0 = read).
- m0_addr_i  in  AW  master 0 address.
- m0_wdata_i  in  DW  master 0 write data.
- m0_ack_o  out  1  one-cycle completion pulse to master 0.
- m0_rdata_o  out  DW  master 0 read data; valid while m0_ack_o = 1.
- m1_req_i / m1_wr_i / m1_addr_i / m1_wdata_i / m1_ack_o / m1_rdata_o: same as master 0, for master 1.
- io_rd_o  out  1  read strobe to the peripheral bus.
- io_wr_o  out  1  write strobe to the peripheral bus.
- io_addr_o  out  AW  bus address (drives the cs decoder).
- io_dout_o  out  DW  bus write data.
- io_din_i  in  DW  muxed peripheral read data.
- busy_o  out  1  high in any state other than IDLE.
- owner_o  out  1  index of the current or most recent grant.

Behaviour:
- Reset values (async, sys_rst_i = 0): state = IDLE; all strobes and acks = 0; io_addr_o, io_dout_o, both rdata = 0; owner_o = 1, so master 0 wins the first tie; latency counter = 0.
- States:
  - IDLE: if any req is high, latch winner, wr, addr, wdata → XFER. Otherwise stay.
  - XFER: exactly one cycle.
    - io_wr_o = latched wr; io_rd_o = !latched wr.
    - Write → ACK.
    - Read with RD_LAT = 0: capture io_din_i → ACK.
    - Read with RD_LAT > 0: load counter = RD_LAT-1 → WAIT.
  - WAIT: no strobes. When counter = 0, capture io_din_i → ACK; otherwise decrement.
  - ACK: pulse the winner's ack_o for one cycle with rdata_o valid → IDLE. Requests are not sampled in ACK, which gives the master one cycle to drop or renew req.
- Arbitration (round-robin):
  - Only one req high: that master wins.
  - Both high: the master != owner_o wins.
  - owner_o updates on entering XFER.
- io_addr_o and io_dout_o hold the latched values from XFER until the next grant. cs therefore stays stable through WAIT and ACK.
- Latency from req sampled in IDLE at cycle N:
  - strobe at N+1;
  - write ack at N+2;
  - read ack at N+2+RD_LAT.
- Back-to-back transfers for one master: minimum 3 + RD_LAT cycles per read.
- Boundary cases:
  - req dropped mid-transfer: ignored; the transfer completes and ack still pulses.
  - Addr/wdata changes after the grant: ignored.
  - Non-winning req: waits, with no ack and no strobe.
  - Reset asserted mid-transfer: immediate return to reset values; a pending ack is lost.
  - Unmapped address: transfer proceeds normally; read returns whatever io_din_i carries (16'h0666 default).
- rdata_o of the non-winning master holds its previous value.

Optional Feature:
- Macro: J1_IO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. When both masters request, master 0 (CPU) always wins; owner_o still reports the grant.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package j1_io_pkg:
  - state encoding (IDLE, XFER, WAIT, ACK);
  - peripheral base constants (8'h67 MULT, 8'h68 DIV, 8'h69 UART, 8'h70 DPRAM);
  - default read value 16'h0666.
- One natural sub-module: j1_rr_arb2, a combinational two-way winner select from req[1:0] and the last owner. The fixed-priority macro is handled inside it.

Test Plan:
- Write test, after reset: m0 write addr 16'h6702, data 16'h0005 → io_wr_o high exactly 1 cycle at N+1 with addr 16'h6702 / dout 16'h0005; m0_ack_o at N+2; io_rd_o never high.
- Read test: RD_LAT=1, io_din_i = 16'hBEEF one cycle after the strobe; m1 read 16'h7010 → io_rd_o at N+1, m1_ack_o at N+3, m1_rdata_o = 16'hBEEF.
- Tie test: both req high from reset, held for 4 transfers → grants m0,m1,m0,m1. With J1_IO_ARB_FIXED_PRIO_EN → m0 each time, m1 never acked.
- Early-drop test: m0 read, m0_req_i dropped in WAIT → transfer completes, m0_ack_o still pulses once; no second strobe.
- Reset-abort test: sys_rst_i low during WAIT → io_rd_o, both acks and busy_o go 0 immediately (async); no ack after release; owner_o = 1.
- Latency-edge test: RD_LAT=0 and RD_LAT=7 reads of 16'h6900 → ack at N+2 and N+9 respectively; data sampled in the correct cycle.
